// File: rtl/hnsn_char_uart.sv
// Character FIFO + 8N1 UART transmitter for the HNSN spike-decoder console output.
// Build option: define HNSN_UART_PARITY_EN to insert an even-parity bit before STOP.
module hnsn_char_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 3,
  parameter bit CHANGED_ONLY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         char_in,
  input  logic               char_valid,
  input  logic               char_changed,
  input  logic               flush,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef HNSN_UART_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t             state, state_d;
  logic [CW-1:0]      baud, baud_d;
  logic [2:0]         bit_idx, bit_d;
  logic [7:0]         data_q, data_d;
  logic               tx_d, busy_d;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               accept, full, empty, pop, push, drop, bit_end;

  assign accept  = CHANGED_ONLY ? char_changed : char_valid;
  assign full    = (fifo_count == FULL_CNT);
  assign empty   = (fifo_count == '0);
  // A pop frees a slot in the same edge, so a full FIFO still takes a push while IDLE pops.
  assign pop     = (state == IDLE) && !empty;
  assign push    = accept && !flush && (!full || pop);
  assign drop    = accept && !flush && full && !pop;
  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= char_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_idx;
    data_d  = data_q;
    case (state)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          data_d  = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else baud_d = baud + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            bit_d = '0;
`ifdef HNSN_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else bit_d = bit_idx + 1'b1;
        end else baud_d = baud + 1'b1;
      end
`ifdef HNSN_UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else baud_d = baud + 1'b1;
      end
`endif
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else baud_d = baud + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so uart_tx/tx_busy come straight off flops.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b1;
    case (state_d)
      IDLE:   busy_d = 1'b0;
      START:  tx_d   = 1'b0;
      DATA:   tx_d   = data_d[bit_d];
`ifdef HNSN_UART_PARITY_EN
      PARITY: tx_d   = ^data_d;
`endif
      default: tx_d  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_d;
      data_q  <= data_d;
      uart_tx <= tx_d;
      tx_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_hnsn_char_uart.sv
// Bench for hnsn_char_uart: frame-timeline model per instance, checked every cycle, plus directed literals.
module tb_hnsn_char_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef HNSN_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_changed = 1'b0;
  logic       flush = 1'b0;
  logic       tx0, busy0, ov0, tx1, busy1, ov1;
  logic [3:0] cnt0, cnt1;

  int total = 0;
  int bad = 0;
  int frames0 = 0;
  int frames1 = 0;
  logic pb0 = 1'b0;
  logic pb1 = 1'b0;

  always #5 clk = ~clk;

  hnsn_char_uart #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .CHANGED_ONLY(1'b1)) u_dut (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_changed(char_changed), .flush(flush), .uart_tx(tx0), .tx_busy(busy0),
    .fifo_count(cnt0), .overflow(ov0));

  hnsn_char_uart #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .CHANGED_ONLY(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .char_in(char_in), .char_valid(char_valid),
    .char_changed(char_changed), .flush(flush), .uart_tx(tx1), .tx_busy(busy1),
    .fifo_count(cnt1), .overflow(ov1));

  // Model: a queue of pending characters and the cycle offset ft into the current frame (-1 = idle).
  for (genvar g = 0; g < 2; g++) begin : mdl
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] cur = 8'h00;
    int ft = -1;
    bit ov = 1'b0;
    bit live = 1'b0;
    always @(posedge clk) begin
      bit acc;
      acc = (g == 0) ? char_changed : char_valid;
      if (rst) begin
        q.delete();
        ov = 1'b0;
        ft = -1;
        live = 1'b1;
      end else begin
        if (ft >= 0) ft = (ft == FL - 1) ? -1 : ft + 1;
        else if (q.size() > 0) begin
          cur = q.pop_front();
          sent.push_back(cur);
          ft = 0;
        end
        if (flush) begin
          q.delete();
          ov = 1'b0;
        end else if (acc) begin
          if (q.size() < DEPTH) q.push_back(char_in);
          else ov = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_line(input logic [7:0] c, input int t);
    int k;
    if (t < 0) return 1'b1;
    k = t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return c[k-1];
`ifdef HNSN_UART_PARITY_EN
    if (k == 9) return ^c;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  // Advance one cycle and compare both instances against the model.
  task automatic step();
    @(negedge clk);
    if (mdl[0].live) begin
      check("tx_a", {31'd0, tx0}, {31'd0, exp_line(mdl[0].cur, mdl[0].ft)});
      check("busy_a", {31'd0, busy0}, {31'd0, mdl[0].ft >= 0});
      check("count_a", {28'd0, cnt0}, mdl[0].q.size());
      check("ovf_a", {31'd0, ov0}, {31'd0, mdl[0].ov});
      check("tx_b", {31'd0, tx1}, {31'd0, exp_line(mdl[1].cur, mdl[1].ft)});
      check("busy_b", {31'd0, busy1}, {31'd0, mdl[1].ft >= 0});
      check("count_b", {28'd0, cnt1}, mdl[1].q.size());
      check("ovf_b", {31'd0, ov1}, {31'd0, mdl[1].ov});
      if (busy0 === 1'b1 && pb0 !== 1'b1) frames0++;
      if (busy1 === 1'b1 && pb1 !== 1'b1) frames1++;
      pb0 = busy0;
      pb1 = busy1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pat [11];
    int f0, f1, s0, busy_sum;
`ifdef HNSN_UART_PARITY_EN
    pat = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1};
`else
    pat = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1};
`endif

    // Reset values
    steps(2);
    check("rst_tx", {31'd0, tx0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_count", {28'd0, cnt0}, 32'd0);
    check("rst_ovf", {31'd0, ov0}, 32'd0);
    rst = 1'b0;
    steps(3);

    // Single character 0x41
    char_in = 8'h41; char_changed = 1'b1;
    step();
    char_changed = 1'b0;
    check("single_count_e0", {28'd0, cnt0}, 32'd1);
    check("single_tx_e0", {31'd0, tx0}, 32'd1);
    busy_sum = 0;
    for (int j = 0; j < FL + 4; j++) begin
      step();
      if (j == 0) check("single_start_e1", {31'd0, tx0}, 32'd0);
      if (j < FL && (j % CPB) == 2) check("single_bit", {31'd0, tx0}, pat[j / CPB]);
      if (busy0 === 1'b1) busy_sum++;
    end
    check("single_busy_len", busy_sum, FL);
    check("single_count_end", {28'd0, cnt0}, 32'd0);

`ifdef HNSN_UART_PARITY_EN
    // Odd number of ones: parity bit 1
    char_in = 8'h43; char_changed = 1'b1;
    step();
    char_changed = 1'b0;
    busy_sum = 0;
    for (int j = 0; j < FL + 4; j++) begin
      step();
      if (j == 9 * CPB + 2) check("parity_43", {31'd0, tx0}, 32'd1);
      if (busy0 === 1'b1) busy_sum++;
    end
    check("parity_len", busy_sum, 32'd44);
`endif

    // CHANGED_ONLY filter
    f0 = frames0; f1 = frames1;
    for (int i = 0; i < 5; i++) begin
      char_in = 8'h61 + 8'(i); char_valid = 1'b1;
      step();
      char_valid = 1'b0;
      step();
    end
    char_in = 8'h66; char_valid = 1'b1; char_changed = 1'b1;
    step();
    char_valid = 1'b0; char_changed = 1'b0;
    steps(280);
    check("filter_frames_co1", frames0 - f0, 32'd1);
    check("filter_frames_co0", frames1 - f1, 32'd6);
    check("filter_last_co1", {24'd0, mdl[0].sent[mdl[0].sent.size() - 1]}, 32'h66);
    check("filter_first_co0", {24'd0, mdl[1].sent[mdl[1].sent.size() - 6]}, 32'h61);

    // Overflow: ten back-to-back characters into depth 8
    f0 = frames0; s0 = mdl[0].sent.size();
    for (int i = 0; i < 10; i++) begin
      char_in = 8'h30 + 8'(i); char_changed = 1'b1;
      step();
    end
    char_changed = 1'b0;
    check("ovf_set_e9", {31'd0, ov0}, 32'd1);
    check("ovf_count_e9", {28'd0, cnt0}, 32'd8);
    steps(400);
    check("ovf_frames", frames0 - f0, 32'd9);
    check("ovf_sent_n", mdl[0].sent.size() - s0, 32'd9);
    for (int i = 0; i < 9; i++)
      if (s0 + i < mdl[0].sent.size())
        check("ovf_order", {24'd0, mdl[0].sent[s0 + i]}, 32'h30 + i);
    check("ovf_sticky", {31'd0, ov0}, 32'd1);

    // Flush during the first frame, with a coincident accept that must be discarded
    f0 = frames0;
    for (int i = 0; i < 4; i++) begin
      char_in = 8'h41 + 8'(i); char_changed = 1'b1;
      step();
    end
    char_changed = 1'b0;
    steps(8);
    flush = 1'b1; char_in = 8'h5a; char_changed = 1'b1;
    step();
    flush = 1'b0; char_changed = 1'b0;
    check("flush_count", {28'd0, cnt0}, 32'd0);
    check("flush_ovf", {31'd0, ov0}, 32'd0);
    check("flush_in_frame", {31'd0, busy0}, 32'd1);
    steps(FL + 20);
    check("flush_frames", frames0 - f0, 32'd1);

    // Reset during DATA bit 3
    char_in = 8'h55; char_changed = 1'b1;
    step();
    char_in = 8'h33;
    step();
    char_changed = 1'b0;
    steps(17);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_tx", {31'd0, tx0}, 32'd1);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_count", {28'd0, cnt0}, 32'd0);
    f0 = frames0;
    steps(60);
    check("midrst_frames", frames0 - f0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
